inst_sequencer: RTL and testbench

- Instruction fetch and sequencing unit that sources `inst_code` and `enable` for the hypercorex instruction decoder.
- Holds a small host-programmable instruction memory and steps a program counter through it.
- Repeats the program for a configured number of loop iterations.
- Gates instruction issue whenever the datapath is stalled, so that no pops, writes or bundles fire on stall cycles.

---
 rtl/inst_sequencer_if.sv | 39 +++
 rtl/inst_sequencer.sv | 119 +++++++++++
 tb/tb_inst_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_sequencer_if.sv
// Host/decoder-facing bundle of the instruction sequencer.
// Master drives program and control, slave issues instructions.
interface inst_sequencer_if #(
  parameter int InstWidth    = 32,
  parameter int InstDepth    = 64,
  parameter int LoopCntWidth = 16,
  parameter int AddrWidth    = $clog2(InstDepth)
);
  logic                    inst_wr_en_i;
  logic [AddrWidth-1:0]    inst_wr_addr_i;
  logic [InstWidth-1:0]    inst_wr_data_i;
  logic                    start_i;
  logic                    halt_i;
  logic                    stall_i;
  logic [AddrWidth-1:0]    end_addr_i;
  logic [LoopCntWidth-1:0] loop_count_i;
  logic [InstWidth-1:0]    inst_code_o;
  logic                    inst_enable_o;
  logic [AddrWidth-1:0]    pc_o;
  logic [LoopCntWidth-1:0] loop_iter_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output inst_wr_en_i, inst_wr_addr_i, inst_wr_data_i,
    output start_i, halt_i, stall_i,
    output end_addr_i, loop_count_i,
    input  inst_code_o, inst_enable_o, pc_o,
    input  loop_iter_o, busy_o, done_o
  );

  modport slave (
    input  inst_wr_en_i, inst_wr_addr_i, inst_wr_data_i,
    input  start_i, halt_i, stall_i,
    input  end_addr_i, loop_count_i,
    output inst_code_o, inst_enable_o, pc_o,
    output loop_iter_o, busy_o, done_o
  );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction fetch/sequencing unit: program memory, PC,
// loop counter and stall-gated issue toward the decoder.
module inst_sequencer #(
  parameter int InstWidth    = 32,
  parameter int InstDepth    = 64,
  parameter int LoopCntWidth = 16,
  parameter int AddrWidth    = $clog2(InstDepth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  inst_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AddrWidth-1:0] LastAddr =
    AddrWidth'(InstDepth - 1);
  localparam logic [AddrWidth-1:0] PcOne =
    AddrWidth'(1);
  localparam logic [LoopCntWidth-1:0] IterOne =
    LoopCntWidth'(1);

  logic [InstWidth-1:0] mem [InstDepth];

  state_t                  state_q, state_d;
  logic [AddrWidth-1:0]    pc_q, pc_d;
  logic [LoopCntWidth-1:0] iter_q, iter_d;
  logic [AddrWidth-1:0]    end_q, end_d;
  logic [LoopCntWidth-1:0] loop_q, loop_d;
  logic                    issue;
  logic                    done;
  logic                    latch;

  assign latch = (state_q == IDLE) && bus.start_i;

  // Clamp the end address and promote a zero loop count to one.
  always_comb begin
    end_d  = bus.end_addr_i;
    loop_d = bus.loop_count_i;
    if (int'(bus.end_addr_i) > InstDepth - 1) end_d = LastAddr;
    if (bus.loop_count_i == '0) loop_d = IterOne;
  end

  // Host writes land only while idle; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && bus.inst_wr_en_i)
      mem[bus.inst_wr_addr_i] <= bus.inst_wr_data_i;
  end

  // State, PC, iteration and latched program bounds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      iter_q  <= '0;
      end_q   <= '0;
      loop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iter_q  <= iter_d;
      if (latch) begin
        end_q  <= end_d;
        loop_q <= loop_d;
      end
    end
  end

  // Next-state: halt wins, then end-of-program wrap or finish.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iter_d  = iter_q;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          pc_d    = '0;
          iter_d  = '0;
        end
      end
      RUN: begin
        issue = !bus.stall_i;
        if (bus.halt_i) begin
          state_d = IDLE;
        end else if (issue) begin
          if (pc_q != end_q) begin
            pc_d = pc_q + PcOne;
          end else if ((iter_q + IterOne) < loop_q) begin
            pc_d   = '0;
            iter_d = iter_q + IterOne;
          end else begin
            iter_d  = iter_q + IterOne;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.inst_enable_o = issue;
  assign bus.inst_code_o   = issue ? mem[pc_q] : '0;
  assign bus.pc_o          = pc_q;
  assign bus.loop_iter_o   = iter_q;
  assign bus.busy_o        = (state_q == RUN);
  assign bus.done_o        = done;

endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized bench for inst_sequencer against a queue-based
// model of the expected instruction stream.
module tb_inst_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_sequencer_if bus ();

  inst_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [64];
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  int run_cyc, stall_cyc, bad_stall, done_seen;
  int done_idx, iter_done, timeout, first_idx;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.inst_wr_en_i   = 1'b1;
    bus.inst_wr_addr_i = 6'(a);
    bus.inst_wr_data_i = d;
    cyc();
    bus.inst_wr_en_i = 1'b0;
    mem_m[a] = d;
  endtask

  function automatic void build_exp(input int e, input int l);
    int ee, ll;
    ee = (e > 63) ? 63 : e;
    ll = (l == 0) ? 1 : l;
    exp_q.delete();
    for (int it = 0; it < ll; it++)
      for (int p = 0; p <= ee; p++)
        exp_q.push_back(mem_m[p]);
  endfunction

  // Starts a program and records what the DUT issues until done.
  task automatic run_program(input int e, input int l,
                             input int pct, input int spc,
                             input int slen);
    int left;
    left = slen;
    got_q.delete();
    run_cyc = 0; stall_cyc = 0; bad_stall = 0;
    done_seen = 0; done_idx = -1; iter_done = -1;
    timeout = 1; first_idx = -1;
    bus.end_addr_i   = 6'(e);
    bus.loop_count_i = 16'(l);
    bus.start_i      = 1'b1;
    cyc();
    bus.start_i      = 1'b0;
    bus.inst_wr_en_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.stall_i = 1'b0;
      if (bus.busy_o) begin
        if (left > 0 && int'(bus.pc_o) == spc) begin
          bus.stall_i = 1'b1;
          left--;
        end else if (int'($urandom_range(99)) < pct) begin
          bus.stall_i = 1'b1;
        end
      end
      @(negedge clk);
      if (bus.busy_o) begin
        run_cyc++;
        if (bus.inst_enable_o) begin
          if (first_idx < 0) first_idx = c;
          got_q.push_back(bus.inst_code_o);
        end else begin
          stall_cyc++;
          if (bus.inst_code_o != '0) bad_stall++;
        end
      end
      if (bus.done_o) begin
        done_seen = 1;
        done_idx  = c;
        iter_done = int'(bus.loop_iter_o);
        timeout   = 0;
      end
      cyc();
      if (done_seen != 0) break;
    end
    bus.stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.inst_code_o, bus.inst_enable_o, bus.pc_o,
         bus.loop_iter_o, bus.busy_o, bus.done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pc=%0d en=%0b busy=%0b",
               bus.pc_o, bus.inst_enable_o, bus.busy_o);
    end
    cyc();
    for (int i = 0; i < 8; i++) wr(i, $urandom);
    bus.end_addr_i   = 6'd7;
    bus.loop_count_i = 16'd1;
    bus.start_i      = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.pc_o == 6'd5) break;
      cyc();
    end
    checks++;
    if (bus.pc_o !== 6'd5 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_reach_pc5 got %0d required 5",
               bus.pc_o);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.inst_code_o, bus.inst_enable_o, bus.pc_o,
         bus.loop_iter_o, bus.busy_o, bus.done_o} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got pc=%0d busy=%0b en=%0b",
               bus.pc_o, bus.busy_o, bus.inst_enable_o);
    end
    cyc();
    run_program(3, 1, 0, -1, 0);
    build_exp(3, 1);
    checks++;
    if (got_q.size() != 4 || first_idx != 0 ||
        got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL restart_pc0 got n=%0d first=%0d code=%h required n=4 first=0 code=%h",
               got_q.size(), first_idx,
               got_q.size() > 0 ? got_q[0] : 32'h0, exp_q[0]);
    end
  endtask

  task automatic test_basic();
    wr(0, 32'h11); wr(1, 32'h22); wr(2, 32'h33); wr(3, 32'h44);
    run_program(3, 1, 0, -1, 0);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL basic_len got %0d required 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== 32'h11 * (i + 1)) begin
          errors++;
          $display("FAIL basic_code[%0d] got %h required %h",
                   i, got_q[i], 32'h11 * (i + 1));
        end
      end
    end
    checks++;
    if (timeout != 0 || done_idx != 4 || iter_done != 1) begin
      errors++;
      $display("FAIL basic_done got idx=%0d iter=%0d required idx=4 iter=1",
               done_idx, iter_done);
    end
  endtask

  task automatic test_loop();
    int lp [2];
    lp[0] = 3;
    lp[1] = 0;
    foreach (lp[k]) begin
      run_program(3, lp[k], 0, -1, 0);
      build_exp(3, lp[k]);
      checks++;
      if (got_q.size() != exp_q.size() ||
          run_cyc != exp_q.size()) begin
        errors++;
        $display("FAIL loop%0d_len got n=%0d run=%0d required %0d",
                 lp[k], got_q.size(), run_cyc, exp_q.size());
      end
      foreach (exp_q[i]) begin
        if (i < got_q.size()) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL loop%0d_code[%0d] got %h required %h",
                     lp[k], i, got_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (timeout != 0 || iter_done != (lp[k] == 0 ? 1 : lp[k])) begin
        errors++;
        $display("FAIL loop%0d_iter got %0d required %0d",
                 lp[k], iter_done, lp[k] == 0 ? 1 : lp[k]);
      end
    end
  endtask

  task automatic test_stall();
    run_program(3, 1, 0, 2, 3);
    build_exp(3, 1);
    checks++;
    if (run_cyc != 7 || stall_cyc != 3 || bad_stall != 0) begin
      errors++;
      $display("FAIL stall_cycles got run=%0d stall=%0d bad=%0d required 7 3 0",
               run_cyc, stall_cyc, bad_stall);
    end
    checks++;
    if (got_q.size() != 4 || got_q[2] !== 32'h33 ||
        got_q[3] !== 32'h44) begin
      errors++;
      $display("FAIL stall_stream got n=%0d required 4 with 0x33 once",
               got_q.size());
    end
  endtask

  task automatic test_random();
    int e, l;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 64; i++)
        if ($urandom_range(3) == 0) wr(i, $urandom);
      e = int'($urandom_range(63));
      l = int'($urandom_range(3));
      run_program(e, l, 30, -1, 0);
      build_exp(e, l);
      checks++;
      if (got_q.size() != exp_q.size() || timeout != 0 ||
          run_cyc != exp_q.size() + stall_cyc ||
          bad_stall != 0 || iter_done != (l == 0 ? 1 : l)) begin
        errors++;
        $display("FAIL rand%0d_shape got n=%0d run=%0d stall=%0d iter=%0d required n=%0d",
                 n, got_q.size(), run_cyc, stall_cyc, iter_done,
                 exp_q.size());
      end
      foreach (exp_q[i]) begin
        if (i < got_q.size() && got_q[i] !== exp_q[i]) begin
          checks++;
          errors++;
          $display("FAIL rand%0d_code[%0d] got %h required %h",
                   n, i, got_q[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_halt();
    int dcount;
    wr(0, 32'h11); wr(1, 32'h22); wr(2, 32'h33); wr(3, 32'h44);
    bus.end_addr_i   = 6'd3;
    bus.loop_count_i = 16'd1;
    bus.start_i      = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.pc_o == 6'd1) break;
      cyc();
    end
    bus.halt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.inst_enable_o !== 1'b1 || bus.inst_code_o !== 32'h22) begin
      errors++;
      $display("FAIL halt_issue got en=%0b code=%h required 1 22",
               bus.inst_enable_o, bus.inst_code_o);
    end
    cyc();
    bus.halt_i = 1'b0;
    dcount = 0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.pc_o !== 6'd1) begin
      errors++;
      $display("FAIL halt_state got busy=%0b pc=%0d required 0 1",
               bus.busy_o, bus.pc_o);
    end
    for (int i = 0; i < 5; i++) begin
      if (bus.done_o) dcount++;
      cyc();
      @(negedge clk);
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL halt_no_done got %0d pulses required 0", dcount);
    end
    cyc();
    bus.start_i = 1'b1;
    cyc();
    bus.start_i        = 1'b0;
    bus.inst_wr_en_i   = 1'b1;
    bus.inst_wr_addr_i = 6'd0;
    bus.inst_wr_data_i = 32'hFF;
    cyc();
    bus.inst_wr_en_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy_o) break;
      cyc();
    end
    cyc(); cyc();
    run_program(0, 1, 0, -1, 0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h11) begin
      errors++;
      $display("FAIL run_write_ignored got n=%0d code=%h required 1 11",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 32'h0);
    end
  endtask

  task automatic test_write_start();
    logic [31:0] d;
    d = $urandom;
    bus.inst_wr_en_i   = 1'b1;
    bus.inst_wr_addr_i = 6'd0;
    bus.inst_wr_data_i = d;
    mem_m[0] = d;
    run_program(0, 1, 0, -1, 0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== d) begin
      errors++;
      $display("FAIL write_start got %h required %h",
               got_q.size() > 0 ? got_q[0] : 32'h0, d);
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 64; i++) wr(i, $urandom);
    run_program(63, 1, 0, -1, 0);
    build_exp(63, 1);
    checks++;
    if (got_q.size() != 64 || timeout != 0 || run_cyc != 64) begin
      errors++;
      $display("FAIL bound_full_len got n=%0d run=%0d required 64",
               got_q.size(), run_cyc);
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size() && got_q[i] !== exp_q[i]) begin
        checks++;
        errors++;
        $display("FAIL bound_full_code[%0d] got %h required %h",
                 i, got_q[i], exp_q[i]);
        break;
      end
    end
    run_program(0, 2, 0, -1, 0);
    checks++;
    if (got_q.size() != 2 || run_cyc != 2 || iter_done != 2 ||
        got_q[0] !== mem_m[0] || got_q[1] !== mem_m[0]) begin
      errors++;
      $display("FAIL bound_zero got n=%0d run=%0d iter=%0d required 2 2 2",
               got_q.size(), run_cyc, iter_done);
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.inst_wr_en_i   = 1'b0;
    bus.inst_wr_addr_i = '0;
    bus.inst_wr_data_i = '0;
    bus.start_i        = 1'b0;
    bus.halt_i         = 1'b0;
    bus.stall_i        = 1'b0;
    bus.end_addr_i     = '0;
    bus.loop_count_i   = '0;
    foreach (mem_m[i]) mem_m[i] = '0;
    test_reset();
    test_basic();
    test_loop();
    test_stall();
    test_halt();
    test_write_start();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
